// File: rtl/mcs51_pkg.sv
// Shared types and constants for the MCS-51 two-level interrupt controller:
// source encoding, vector addresses and IE/IP bit positions.
package mcs51_pkg;

    typedef enum logic [2:0] {
        SRC_INT0   = 3'd0,
        SRC_T0     = 3'd1,
        SRC_INT1   = 3'd2,
        SRC_T1     = 3'd3,
        SRC_SERIAL = 3'd4
    } intc_src_e;

    localparam logic [15:0] VEC_INT0   = 16'h0003;
    localparam logic [15:0] VEC_T0     = 16'h000B;
    localparam logic [15:0] VEC_INT1   = 16'h0013;
    localparam logic [15:0] VEC_T1     = 16'h001B;
    localparam logic [15:0] VEC_SERIAL = 16'h0023;

    localparam int IE_EX0 = 0;
    localparam int IE_ET0 = 1;
    localparam int IE_EX1 = 2;
    localparam int IE_ET1 = 3;
    localparam int IE_ES  = 4;
    localparam int IE_EA  = 7;

    localparam int IP_PX0 = 0;
    localparam int IP_PT0 = 1;
    localparam int IP_PX1 = 2;
    localparam int IP_PT1 = 3;
    localparam int IP_PS  = 4;

    function automatic logic [15:0] src_vec(input intc_src_e src);
        logic [15:0] vec;
        case (src)
            SRC_INT0:   vec = VEC_INT0;
            SRC_T0:     vec = VEC_T0;
            SRC_INT1:   vec = VEC_INT1;
            SRC_T1:     vec = VEC_T1;
            SRC_SERIAL: vec = VEC_SERIAL;
            default:    vec = VEC_INT0;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/mcs51_intc_if.sv
// Core-side handshake of the interrupt controller: request/vector out,
// acknowledge/RETI in, plus service status.
interface mcs51_intc_if;
    logic        int_ack;
    logic        reti_pulse;
    logic        int_req;
    logic [15:0] int_vector;
    logic        int_prio;
    logic [1:0]  in_service;
    logic        spurious_ack;

    modport master (
        output int_ack, reti_pulse,
        input  int_req, int_vector, int_prio, in_service, spurious_ack
    );

    modport slave (
        input  int_ack, reti_pulse,
        output int_req, int_vector, int_prio, in_service, spurious_ack
    );
endinterface

// File: rtl/mcs51_intc_sel.sv
// Fixed-priority encoder for one priority level: bit 0 (INT0) wins,
// bit 4 (SERIAL) loses.
module mcs51_intc_sel
    import mcs51_pkg::*;
(
    input  logic [4:0]  act_i,
    output logic        valid_o,
    output intc_src_e   src_o,
    output logic [15:0] vec_o
);

    intc_src_e src_s;

    // Pick the lowest-numbered active source and map it to its vector.
    always_comb begin
        valid_o = |act_i;
        if (act_i[0]) begin
            src_s = SRC_INT0;
        end else if (act_i[1]) begin
            src_s = SRC_T0;
        end else if (act_i[2]) begin
            src_s = SRC_INT1;
        end else if (act_i[3]) begin
            src_s = SRC_T1;
        end else if (act_i[4]) begin
            src_s = SRC_SERIAL;
        end else begin
            src_s = SRC_INT0;
        end
        src_o = src_s;
        vec_o = src_vec(src_s);
    end

endmodule

// File: rtl/mcs51_intc.sv
// Two-level MCS-51 interrupt controller: registered request/vector/priority,
// per-level in-service tracking, flag-clear pulses and post-RETI hold-off.
module mcs51_intc
    import mcs51_pkg::*;
#(
    parameter int RETI_HOLDOFF = 2,
    parameter int NUM_SRC      = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    mcs51_intc_if.slave  core,
    input  logic [7:0]   ie,
    input  logic [7:0]   ip,
    input  logic         flag_ie0,
    input  logic         flag_tf0,
    input  logic         flag_ie1,
    input  logic         flag_tf1,
    input  logic         flag_ri,
    input  logic         flag_ti,
    input  logic         it0,
    input  logic         it1,
    output logic         clr_ie0,
    output logic         clr_tf0,
    output logic         clr_ie1,
    output logic         clr_tf1
);

    localparam int HOLD_W = (RETI_HOLDOFF > 1) ? $clog2(RETI_HOLDOFF + 1) : 1;

    logic [NUM_SRC-1:0] act_s, hi_act_s, lo_act_s;
    logic               hi_vld_s, lo_vld_s, ack_ok_s;
    intc_src_e          hi_src_s, lo_src_s;
    logic [15:0]        hi_vec_s, lo_vec_s;
    logic [1:0]         is_reti_s;
    logic               unused_s;

    logic              int_req_d, int_req_q;
    logic [15:0]       int_vector_d, int_vector_q;
    logic              int_prio_d, int_prio_q;
    intc_src_e         src_d, src_q;
    logic [1:0]        in_service_d, in_service_q;
    logic [HOLD_W-1:0] hold_d, hold_q;
    logic              spurious_d, spurious_q;
    logic              clr_ie0_d, clr_ie0_q, clr_tf0_d, clr_tf0_q;
    logic              clr_ie1_d, clr_ie1_q, clr_tf1_d, clr_tf1_q;

    assign act_s    = {flag_ri | flag_ti, flag_tf1, flag_ie1, flag_tf0, flag_ie0}
                    & ie[NUM_SRC-1:0] & {NUM_SRC{ie[IE_EA]}};
    assign hi_act_s = act_s & ip[NUM_SRC-1:0];
    assign lo_act_s = act_s & ~ip[NUM_SRC-1:0];
    assign unused_s = ^{ie[6:5], ip[7:5]};

    mcs51_intc_sel u_sel_hi (
        .act_i   (hi_act_s),
        .valid_o (hi_vld_s),
        .src_o   (hi_src_s),
        .vec_o   (hi_vec_s)
    );

    mcs51_intc_sel u_sel_lo (
        .act_i   (lo_act_s),
        .valid_o (lo_vld_s),
        .src_o   (lo_src_s),
        .vec_o   (lo_vec_s)
    );

    // Next-state: RETI before ACK, then pick against the post-update
    // in-service state so an acked level is masked in the following cycle.
    always_comb begin
        ack_ok_s = core.int_ack & int_req_q;

        if (core.reti_pulse && in_service_q[1]) begin
            is_reti_s = {1'b0, in_service_q[0]};
        end else if (core.reti_pulse && in_service_q[0]) begin
            is_reti_s = 2'b00;
        end else begin
            is_reti_s = in_service_q;
        end

        if (ack_ok_s) begin
            in_service_d = is_reti_s | (int_prio_q ? 2'b10 : 2'b01);
        end else begin
            in_service_d = is_reti_s;
        end

        if (core.reti_pulse) begin
            hold_d = HOLD_W'(RETI_HOLDOFF);
        end else if (hold_q != {HOLD_W{1'b0}}) begin
            hold_d = hold_q - {{(HOLD_W-1){1'b0}}, 1'b1};
        end else begin
            hold_d = hold_q;
        end

        int_req_d    = 1'b0;
        int_vector_d = int_vector_q;
        int_prio_d   = int_prio_q;
        src_d        = src_q;
        if (hold_d != {HOLD_W{1'b0}}) begin
            int_req_d = 1'b0;
        end else if (hi_vld_s && !in_service_d[1]) begin
            int_req_d    = 1'b1;
            int_vector_d = hi_vec_s;
            int_prio_d   = 1'b1;
            src_d        = hi_src_s;
        end else if (lo_vld_s && (in_service_d == 2'b00)) begin
            int_req_d    = 1'b1;
            int_vector_d = lo_vec_s;
            int_prio_d   = 1'b0;
            src_d        = lo_src_s;
        end else begin
            int_req_d = 1'b0;
        end

        // External-interrupt flags are only hardware-cleared when edge-triggered.
        clr_ie0_d  = ack_ok_s & (src_q == SRC_INT0) & it0;
        clr_tf0_d  = ack_ok_s & (src_q == SRC_T0);
        clr_ie1_d  = ack_ok_s & (src_q == SRC_INT1) & it1;
        clr_tf1_d  = ack_ok_s & (src_q == SRC_T1);
        spurious_d = spurious_q | (core.int_ack & ~int_req_q);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            int_req_q    <= 1'b0;
            int_vector_q <= 16'h0000;
            int_prio_q   <= 1'b0;
            src_q        <= SRC_INT0;
            in_service_q <= 2'b00;
            hold_q       <= {HOLD_W{1'b0}};
            spurious_q   <= 1'b0;
            clr_ie0_q    <= 1'b0;
            clr_tf0_q    <= 1'b0;
            clr_ie1_q    <= 1'b0;
            clr_tf1_q    <= 1'b0;
        end else begin
            int_req_q    <= int_req_d;
            int_vector_q <= int_vector_d;
            int_prio_q   <= int_prio_d;
            src_q        <= src_d;
            in_service_q <= in_service_d;
            hold_q       <= hold_d;
            spurious_q   <= spurious_d;
            clr_ie0_q    <= clr_ie0_d;
            clr_tf0_q    <= clr_tf0_d;
            clr_ie1_q    <= clr_ie1_d;
            clr_tf1_q    <= clr_tf1_d;
        end
    end

    assign core.int_req      = int_req_q;
    assign core.int_vector   = int_vector_q;
    assign core.int_prio     = int_prio_q;
    assign core.in_service   = in_service_q;
    assign core.spurious_ack = spurious_q;
    assign clr_ie0           = clr_ie0_q;
    assign clr_tf0           = clr_tf0_q;
    assign clr_ie1           = clr_ie1_q;
    assign clr_tf1           = clr_tf1_q;

endmodule

// File: tb/tb_mcs51_intc.sv
// Directed bench for mcs51_intc: each task drives one scenario and checks
// outputs one time unit after the rising edge against hand-computed values.
module tb_mcs51_intc;

    logic       clk;
    logic       reset_n;
    logic [7:0] ie, ip;
    logic       flag_ie0, flag_tf0, flag_ie1, flag_tf1, flag_ri, flag_ti;
    logic       it0, it1;
    logic       clr_ie0, clr_tf0, clr_ie1, clr_tf1;
    int         n_chk;
    int         n_pass;

    mcs51_intc_if cif ();

    mcs51_intc #(.RETI_HOLDOFF(2), .NUM_SRC(5)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .core     (cif),
        .ie       (ie),
        .ip       (ip),
        .flag_ie0 (flag_ie0),
        .flag_tf0 (flag_tf0),
        .flag_ie1 (flag_ie1),
        .flag_tf1 (flag_tf1),
        .flag_ri  (flag_ri),
        .flag_ti  (flag_ti),
        .it0      (it0),
        .it1      (it1),
        .clr_ie0  (clr_ie0),
        .clr_tf0  (clr_tf0),
        .clr_ie1  (clr_ie1),
        .clr_tf1  (clr_tf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        ie = 8'h00; ip = 8'h00;
        flag_ie0 = 1'b0; flag_tf0 = 1'b0; flag_ie1 = 1'b0;
        flag_tf1 = 1'b0; flag_ri = 1'b0; flag_ti = 1'b0;
        it0 = 1'b0; it1 = 1'b0;
        cif.int_ack = 1'b0; cif.reti_pulse = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        clear_inputs();
        reset_n = 1'b0;
        tick();
        n_chk++; if (cif.int_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", cif.int_req); else n_pass++;
        n_chk++; if (cif.int_vector !== 16'h0000) $display("FAIL reset_vec got=%h exp=0000", cif.int_vector); else n_pass++;
        n_chk++; if (cif.int_prio !== 1'b0) $display("FAIL reset_prio got=%b exp=0", cif.int_prio); else n_pass++;
        n_chk++; if (cif.in_service !== 2'b00) $display("FAIL reset_insvc got=%b exp=00", cif.in_service); else n_pass++;
        n_chk++; if (cif.spurious_ack !== 1'b0) $display("FAIL reset_spur got=%b exp=0", cif.spurious_ack); else n_pass++;
        n_chk++; if ({clr_ie0, clr_tf0, clr_ie1, clr_tf1} !== 4'b0000)
            $display("FAIL reset_clr got=%b exp=0000", {clr_ie0, clr_tf0, clr_ie1, clr_tf1}); else n_pass++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_low_int0;
        do_reset();
        ie = 8'h81; ip = 8'h00; it0 = 1'b1; flag_ie0 = 1'b1;
        tick();
        n_chk++; if (cif.int_req !== 1'b1) $display("FAIL int0_req got=%b exp=1", cif.int_req); else n_pass++;
        n_chk++; if (cif.int_vector !== 16'h0003) $display("FAIL int0_vec got=%h exp=0003", cif.int_vector); else n_pass++;
        n_chk++; if (cif.int_prio !== 1'b0) $display("FAIL int0_prio got=%b exp=0", cif.int_prio); else n_pass++;
        cif.int_ack = 1'b1;
        tick();
        cif.int_ack = 1'b0; flag_ie0 = 1'b0;
        n_chk++; if (clr_ie0 !== 1'b1) $display("FAIL int0_clr got=%b exp=1", clr_ie0); else n_pass++;
        n_chk++; if ({clr_tf0, clr_ie1, clr_tf1} !== 3'b000) $display("FAIL int0_other_clr got=%b exp=000", {clr_tf0, clr_ie1, clr_tf1}); else n_pass++;
        n_chk++; if (cif.in_service !== 2'b01) $display("FAIL int0_insvc got=%b exp=01", cif.in_service); else n_pass++;
        n_chk++; if (cif.int_req !== 1'b0) $display("FAIL int0_req_after_ack got=%b exp=0", cif.int_req); else n_pass++;
        tick();
        n_chk++; if (clr_ie0 !== 1'b0) $display("FAIL int0_clr_width got=%b exp=0", clr_ie0); else n_pass++;
    endtask

    task automatic test_preempt;
        do_reset();
        ie = 8'h8A; ip = 8'h00; flag_tf0 = 1'b1;
        tick();
        n_chk++; if (cif.int_vector !== 16'h000B) $display("FAIL pre_t0_vec got=%h exp=000B", cif.int_vector); else n_pass++;
        cif.int_ack = 1'b1;
        tick();
        cif.int_ack = 1'b0; flag_tf0 = 1'b0;
        n_chk++; if (clr_tf0 !== 1'b1) $display("FAIL pre_t0_clr got=%b exp=1", clr_tf0); else n_pass++;
        n_chk++; if (cif.in_service !== 2'b01) $display("FAIL pre_t0_insvc got=%b exp=01", cif.in_service); else n_pass++;
        ip = 8'h08; flag_tf1 = 1'b1;
        tick();
        n_chk++; if (cif.int_req !== 1'b1) $display("FAIL pre_t1_req got=%b exp=1", cif.int_req); else n_pass++;
        n_chk++; if (cif.int_vector !== 16'h001B) $display("FAIL pre_t1_vec got=%h exp=001B", cif.int_vector); else n_pass++;
        n_chk++; if (cif.int_prio !== 1'b1) $display("FAIL pre_t1_prio got=%b exp=1", cif.int_prio); else n_pass++;
        cif.int_ack = 1'b1;
        tick();
        cif.int_ack = 1'b0; flag_tf1 = 1'b0;
        n_chk++; if (cif.in_service !== 2'b11) $display("FAIL pre_insvc got=%b exp=11", cif.in_service); else n_pass++;
        n_chk++; if (clr_tf1 !== 1'b1) $display("FAIL pre_t1_clr got=%b exp=1", clr_tf1); else n_pass++;
        flag_tf0 = 1'b1; flag_tf1 = 1'b1;
        tick();
        tick();
        n_chk++; if (cif.int_req !== 1'b0) $display("FAIL pre_blocked_req got=%b exp=0", cif.int_req); else n_pass++;
        n_chk++; if (cif.in_service !== 2'b11) $display("FAIL pre_flags_keep_insvc got=%b exp=11", cif.in_service); else n_pass++;
    endtask

    // Continues from in_service == 2'b11 left by test_preempt.
    task automatic test_reti_holdoff;
        flag_tf0 = 1'b0; flag_tf1 = 1'b0;
        ie = 8'h84; ip = 8'h00; it1 = 1'b1; flag_ie1 = 1'b1;
        cif.reti_pulse = 1'b1;
        tick();
        cif.reti_pulse = 1'b0;
        n_chk++; if (cif.in_service !== 2'b01) $display("FAIL reti1_insvc got=%b exp=01", cif.in_service); else n_pass++;
        tick();
        tick();
        n_chk++; if (cif.int_req !== 1'b0) $display("FAIL reti1_low_blocked got=%b exp=0", cif.int_req); else n_pass++;
        cif.reti_pulse = 1'b1;
        tick();
        cif.reti_pulse = 1'b0;
        n_chk++; if (cif.in_service !== 2'b00) $display("FAIL reti2_insvc got=%b exp=00", cif.in_service); else n_pass++;
        n_chk++; if (cif.int_req !== 1'b0) $display("FAIL hold_c0 got=%b exp=0", cif.int_req); else n_pass++;
        tick();
        n_chk++; if (cif.int_req !== 1'b0) $display("FAIL hold_c1 got=%b exp=0", cif.int_req); else n_pass++;
        tick();
        n_chk++; if (cif.int_req !== 1'b1) $display("FAIL hold_release got=%b exp=1", cif.int_req); else n_pass++;
        n_chk++; if (cif.int_vector !== 16'h0013) $display("FAIL hold_int1_vec got=%h exp=0013", cif.int_vector); else n_pass++;
    endtask

    task automatic test_simultaneous_flags;
        do_reset();
        ie = 8'h9F; ip = 8'h00; it0 = 1'b1; it1 = 1'b1;
        flag_ie0 = 1'b1; flag_tf0 = 1'b1; flag_ie1 = 1'b1;
        flag_tf1 = 1'b1; flag_ri = 1'b1; flag_ti = 1'b1;
        tick();
        n_chk++; if (cif.int_vector !== 16'h0003) $display("FAIL all_first_vec got=%h exp=0003", cif.int_vector); else n_pass++;
        cif.int_ack = 1'b1;
        tick();
        cif.int_ack = 1'b0; flag_ie0 = 1'b0;
        n_chk++; if ({clr_ie0, clr_tf0, clr_ie1, clr_tf1} !== 4'b1000)
            $display("FAIL all_clr got=%b exp=1000", {clr_ie0, clr_tf0, clr_ie1, clr_tf1}); else n_pass++;
        cif.reti_pulse = 1'b1;
        tick();
        cif.reti_pulse = 1'b0;
        tick();
        tick();
        n_chk++; if (cif.int_req !== 1'b1) $display("FAIL all_second_req got=%b exp=1", cif.int_req); else n_pass++;
        n_chk++; if (cif.int_vector !== 16'h000B) $display("FAIL all_second_vec got=%h exp=000B", cif.int_vector); else n_pass++;
    endtask

    task automatic test_reti_ack_same_cycle;
        do_reset();
        ie = 8'h91; ip = 8'h10; it0 = 1'b1; flag_ie0 = 1'b1;
        tick();
        cif.int_ack = 1'b1;
        tick();
        cif.int_ack = 1'b0; flag_ie0 = 1'b0; flag_ri = 1'b1;
        tick();
        n_chk++; if (cif.int_vector !== 16'h0023) $display("FAIL same_ser_vec got=%h exp=0023", cif.int_vector); else n_pass++;
        n_chk++; if (cif.int_prio !== 1'b1) $display("FAIL same_ser_prio got=%b exp=1", cif.int_prio); else n_pass++;
        cif.int_ack = 1'b1; cif.reti_pulse = 1'b1;
        tick();
        cif.int_ack = 1'b0; cif.reti_pulse = 1'b0; flag_ri = 1'b0;
        n_chk++; if (cif.in_service !== 2'b10) $display("FAIL same_insvc got=%b exp=10", cif.in_service); else n_pass++;
        n_chk++; if (cif.spurious_ack !== 1'b0) $display("FAIL same_spur got=%b exp=0", cif.spurious_ack); else n_pass++;
        n_chk++; if ({clr_ie0, clr_tf0, clr_ie1, clr_tf1} !== 4'b0000)
            $display("FAIL same_ser_clr got=%b exp=0000", {clr_ie0, clr_tf0, clr_ie1, clr_tf1}); else n_pass++;
    endtask

    task automatic test_level_and_serial;
        do_reset();
        ie = 8'h81; ip = 8'h00; it0 = 1'b0; flag_ie0 = 1'b1;
        tick();
        n_chk++; if (cif.int_req !== 1'b1) $display("FAIL lvl_req got=%b exp=1", cif.int_req); else n_pass++;
        cif.int_ack = 1'b1;
        tick();
        cif.int_ack = 1'b0;
        n_chk++; if (clr_ie0 !== 1'b0) $display("FAIL lvl_no_clr got=%b exp=0", clr_ie0); else n_pass++;
        n_chk++; if (cif.in_service !== 2'b01) $display("FAIL lvl_insvc got=%b exp=01", cif.in_service); else n_pass++;
        flag_ie0 = 1'b0; ie = 8'h90; flag_ti = 1'b1;
        cif.reti_pulse = 1'b1;
        tick();
        cif.reti_pulse = 1'b0;
        tick();
        tick();
        n_chk++; if (cif.int_vector !== 16'h0023) $display("FAIL ser_vec got=%h exp=0023", cif.int_vector); else n_pass++;
        cif.int_ack = 1'b1;
        tick();
        cif.int_ack = 1'b0;
        n_chk++; if ({clr_ie0, clr_tf0, clr_ie1, clr_tf1} !== 4'b0000)
            $display("FAIL ser_no_clr got=%b exp=0000", {clr_ie0, clr_tf0, clr_ie1, clr_tf1}); else n_pass++;
        n_chk++; if (cif.in_service !== 2'b01) $display("FAIL ser_insvc got=%b exp=01", cif.in_service); else n_pass++;
    endtask

    // Continues from serial in service with int_req low.
    task automatic test_spurious_and_reset;
        cif.int_ack = 1'b1;
        tick();
        cif.int_ack = 1'b0;
        n_chk++; if (cif.spurious_ack !== 1'b1) $display("FAIL spur_set got=%b exp=1", cif.spurious_ack); else n_pass++;
        n_chk++; if (cif.in_service !== 2'b01) $display("FAIL spur_insvc got=%b exp=01", cif.in_service); else n_pass++;
        tick();
        n_chk++; if (cif.spurious_ack !== 1'b1) $display("FAIL spur_sticky got=%b exp=1", cif.spurious_ack); else n_pass++;
        ie = 8'h91; ip = 8'h01; it0 = 1'b1; flag_ie0 = 1'b1;
        tick();
        n_chk++; if (cif.int_prio !== 1'b1) $display("FAIL rst_hi_prio got=%b exp=1", cif.int_prio); else n_pass++;
        cif.int_ack = 1'b1;
        tick();
        cif.int_ack = 1'b0;
        n_chk++; if (clr_ie0 !== 1'b1) $display("FAIL rst_pre_clr got=%b exp=1", clr_ie0); else n_pass++;
        #1 reset_n = 1'b0;
        #1;
        n_chk++; if (cif.in_service !== 2'b00) $display("FAIL rst_mid_insvc got=%b exp=00", cif.in_service); else n_pass++;
        n_chk++; if (clr_ie0 !== 1'b0) $display("FAIL rst_mid_clr got=%b exp=0", clr_ie0); else n_pass++;
        n_chk++; if ({cif.int_req, cif.int_prio, cif.spurious_ack} !== 3'b000)
            $display("FAIL rst_mid_flags got=%b exp=000", {cif.int_req, cif.int_prio, cif.spurious_ack}); else n_pass++;
        n_chk++; if (cif.int_vector !== 16'h0000) $display("FAIL rst_mid_vec got=%h exp=0000", cif.int_vector); else n_pass++;
        clear_inputs();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_low_int0();
        test_preempt();
        test_reti_holdoff();
        test_simultaneous_flags();
        test_reti_ack_same_cycle();
        test_level_and_serial();
        test_spurious_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mcs51_intc.md
Name: mcs51_intc

Overview:
- Two-level interrupt controller for the MCS-51 MCU. It replaces the combinational interrupt select in the MCU top.
- Takes IE/IP plus the raw flag bits from TCON/SCON, and tracks in-service state per priority level (low, high).
- Presents one registered request, vector and priority to the core, honouring 8051 nesting rules.
- Issues flag-clear pulses on acknowledge and enforces a hold-off after RETI.

Parameters:
- RETI_HOLDOFF, 2, cycles after reti_pulse during which int_req is forced low (0 = no hold-off).
- NUM_SRC, 5, number of interrupt sources; fixed at 5 (INT0, T0, INT1, T1, SERIAL); other values are unsupported.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- ie  in  8  IE SFR value (bit 7 EA; bits 0..4 per-source enables)
- ip  in  8  IP SFR value (bits 0..4 per-source high priority)
- flag_ie0  in  1  TCON.IE0
- flag_tf0  in  1  TCON.TF0
- flag_ie1  in  1  TCON.IE1
- flag_tf1  in  1  TCON.TF1
- flag_ri  in  1  SCON.RI
- flag_ti  in  1  SCON.TI
- it0  in  1  TCON.IT0 (1 = edge-triggered)
- it1  in  1  TCON.IT1
- int_ack  in  1  core accepts the current request (1-cycle pulse)
- reti_pulse  in  1  core executed RETI (1-cycle pulse)
- int_req  out  1  registered request to core
- int_vector  out  16  registered vector address
- int_prio  out  1  registered priority of the presented request
- clr_ie0  out  1  1-cycle pulse: clear TCON.IE0
- clr_tf0  out  1  1-cycle pulse: clear TCON.TF0
- clr_ie1  out  1  1-cycle pulse: clear TCON.IE1
- clr_tf1  out  1  1-cycle pulse: clear TCON.TF1
- in_service  out  2  {high, low} in-service bits
- spurious_ack  out  1  sticky: set when int_ack arrives while int_req is 0

Behaviour:
- Reset: all outputs 0, in_service 2'b00, hold-off counter 0.
- Source order within a level: INT0 > T0 > INT1 > T1 > SERIAL. Active means ie[EA] & ie[n] & flag; the serial flag is RI|TI.
- Candidate selection, combinational:
  - high candidate = first active source with ip[n]=1.
  - low candidate = first active source with ip[n]=0.
- Eligibility:
  - High is eligible only if in_service[1]=0.
  - Low is eligible only if in_service==2'b00.
  - Pick high if eligible and present, else low.
- Output register:
  - int_req/vector/prio update every cycle from the pick, so a flag change reaches int_req with 1-cycle latency.
  - int_req=0 while the hold-off counter is nonzero.
  - int_vector holds its last value when int_req=0.
- Acknowledge (int_ack & int_req): sets in_service[int_prio] and latches the presented source. In the next cycle:
  - Exactly one clr pulse fires for that source.
  - clr_ie0 fires only if it0=1; clr_ie1 fires only if it1=1.
  - Serial produces no pulse.
  - Because that level is now in service, int_req is 0 in that cycle unless a higher-level request exists.
- int_ack with int_req=0: ignored, sets spurious_ack, which stays set until reset.
- reti_pulse:
  - Clears in_service[1] if set, else in_service[0].
  - Ignored if in_service==0.
  - Loads the hold-off counter with RETI_HOLDOFF; the counter decrements to 0.
- Simultaneous reti_pulse and int_ack: RETI is applied first, then the ACK. The hold-off still loads.
- Changes to IE/IP/flags never alter in_service.
- Vectors:
  - INT0 16'h0003
  - T0 16'h000B
  - INT1 16'h0013
  - T1 16'h001B
  - SERIAL 16'h0023
- Asynchronous reset mid-service clears in_service and any pending clr pulse immediately.

Decomposition:
- mcs51_pkg: typedef enum logic [2:0] intc_src_e {SRC_INT0, SRC_T0, SRC_INT1, SRC_T1, SRC_SERIAL}.
- mcs51_pkg also holds the VEC_* constants and the IE_*/IP_* bit indices.
- Sub-module mcs51_intc_sel: combinational fixed-priority encoder (5-bit active vector in; valid, source and vector out). Instantiated twice, once for the high level and once for the low level.

Test Plan:
- Low-level INT0: ie=8'h81, ip=0, it0=1, flag_ie0=1 -> int_req=1 next cycle, vector 16'h0003, prio 0; ack -> clr_ie0 pulse next cycle, in_service=01, int_req=0.
- Preemption: in_service=01 (T0 low active); ip=8'h08, ie=8'h8A, flag_tf1=1 -> int_req=1, vector 16'h001B, prio 1; ack -> in_service=11; a further low or high flag -> int_req stays 0.
- RETI and hold-off: in_service=11, RETI_HOLDOFF=2, reti -> in_service=01, int_req=0 for 2 cycles; second reti -> 00; pending INT1 -> req at vector 16'h0013 after hold-off.
- Simultaneous flags: ie=8'h9F, ip=0, all flags=1 -> vector 16'h0003; after ack and reti, the next request is 16'h000B.
- Level-triggered INT0 and serial ack: it0=0, ack INT0 -> no clr_ie0 pulse; serial request (flag_ti=1) ack -> no clr pulse, vector 16'h0023.
- Spurious ack and reset: int_ack with int_req=0 -> spurious_ack=1 and sticky; reset_n low mid-service -> in_service=00, all outputs 0.
